// File: rtl/remote_comm_if.sv
// remote_comm_if: host command link bundle between the remote_comm block and whatever drives it
//   RX       serial input into remote_comm (idle high)
//   TX       serial output from remote_comm (idle high)
//   cmd      16-bit command word, snd_cmd one-cycle send request
//   cmd_snt  both command bytes have left TX
//   resp_rdy new response byte available, resp last received byte
//   slave modport: remote_comm side; master modport: host/driver side
interface remote_comm_if;
  logic RX;
  logic TX;
  logic [15:0] cmd;
  logic snd_cmd;
  logic cmd_snt;
  logic resp_rdy;
  logic [7:0] resp;
  modport master (output RX, cmd, snd_cmd, input TX, cmd_snt, resp_rdy, resp);
  modport slave (input RX, cmd, snd_cmd, output TX, cmd_snt, resp_rdy, resp);
endinterface

// File: rtl/remote_comm.sv
// remote_comm: sends a 16-bit command as two 8N1 UART bytes (high first) and receives 8-bit responses
//   clk   system clock
//   rst_n asynchronous active-low reset
//   bus   remote_comm_if.slave (RX, TX, cmd, snd_cmd, cmd_snt, resp_rdy, resp)
//   BAUD_DIV clocks per UART bit, must be >= 8
//   RC_RESP_STICKY_EN: when defined resp_rdy is a level cleared by the next accepted snd_cmd
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input logic clk,
  input logic rst_n,
  remote_comm_if.slave bus
);
  localparam logic [15:0] L_BIT = 16'(BAUD_DIV - 1);
  localparam logic [15:0] L_HALF = 16'(BAUD_DIV / 2);
  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_t;
  state_t r_state, w_state_nxt;
  logic [15:0] r_cmd;
  logic r_tx_start, r_cmd_snt;
  logic w_accept, w_start, w_snt_set;
  logic r_tx_busy;
  logic [9:0] r_tx_sh;
  logic [15:0] r_tx_cnt;
  logic [3:0] r_tx_bit;
  logic w_tx_tick, w_tx_done;
  logic [7:0] w_tx_byte;
  logic r_rx_s1, r_rx_s2, r_rx_s3, r_rx_busy;
  logic [15:0] r_rx_cnt;
  logic [3:0] r_rx_bit;
  logic [7:0] r_rx_sh, r_resp;
  logic r_resp_rdy;
  logic w_rx_smp, w_rx_ok;
  always_comb begin
    w_state_nxt = r_state;
    w_accept = 1'b0;
    w_start = 1'b0;
    w_snt_set = 1'b0;
    case (r_state)
      IDLE: if (bus.snd_cmd) begin
        w_state_nxt = SEND_HI;
        w_accept = 1'b1;
        w_start = 1'b1;
      end
      SEND_HI: if (w_tx_done) begin
        w_state_nxt = SEND_LO;
        w_start = 1'b1;
      end
      SEND_LO: if (w_tx_done) begin
        w_state_nxt = IDLE;
        w_snt_set = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cmd <= 16'h0000;
      r_tx_start <= 1'b0;
      r_cmd_snt <= 1'b0;
    end else begin
      r_cmd <= w_accept ? bus.cmd : r_cmd;
      r_tx_start <= w_start;
      r_cmd_snt <= w_snt_set | (r_cmd_snt & ~w_accept);
    end
  // the start pulse is registered, so the state has already advanced when the engine loads
  assign w_tx_byte = (r_state == SEND_HI) ? r_cmd[15:8] : r_cmd[7:0];
  assign w_tx_tick = r_tx_cnt == L_BIT;
  assign w_tx_done = r_tx_busy & w_tx_tick & (r_tx_bit == 4'd9);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tx_busy <= 1'b0;
      r_tx_sh <= 10'h3ff;
      r_tx_cnt <= 16'h0000;
      r_tx_bit <= 4'd0;
    end else if (r_tx_start) begin
      r_tx_busy <= 1'b1;
      r_tx_sh <= {1'b1, w_tx_byte, 1'b0};
      r_tx_cnt <= 16'h0000;
      r_tx_bit <= 4'd0;
    end else if (r_tx_busy) begin
      r_tx_cnt <= w_tx_tick ? 16'h0000 : r_tx_cnt + 16'd1;
      if (w_tx_tick) begin
        r_tx_sh <= {1'b1, r_tx_sh[9:1]};
        r_tx_bit <= r_tx_bit + 4'd1;
        r_tx_busy <= r_tx_bit != 4'd9;
      end
    end
  assign bus.TX = r_tx_busy ? r_tx_sh[0] : 1'b1;
  assign w_rx_smp = r_rx_busy & (r_rx_cnt == 16'h0000);
  assign w_rx_ok = w_rx_smp & (r_rx_bit == 4'd9) & r_rx_s2;
  // r_rx_bit: 0 start sample, 1..8 data, 9 stop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
      r_rx_busy <= 1'b0;
      r_rx_cnt <= 16'h0000;
      r_rx_bit <= 4'd0;
      r_rx_sh <= 8'h00;
    end else begin
      r_rx_s1 <= bus.RX;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      if (!r_rx_busy) begin
        if (r_rx_s3 & ~r_rx_s2) begin
          r_rx_busy <= 1'b1;
          r_rx_cnt <= L_HALF;
          r_rx_bit <= 4'd0;
        end
      end else if (r_rx_cnt != 16'h0000) r_rx_cnt <= r_rx_cnt - 16'd1;
      else begin
        r_rx_cnt <= L_BIT;
        r_rx_bit <= r_rx_bit + 4'd1;
        if (r_rx_bit == 4'd0) r_rx_busy <= ~r_rx_s2;
        else if (r_rx_bit == 4'd9) r_rx_busy <= 1'b0;
        else r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_resp <= 8'h00;
      r_resp_rdy <= 1'b0;
    end else begin
      r_resp <= w_rx_ok ? r_rx_sh : r_resp;
`ifdef RC_RESP_STICKY_EN
      r_resp_rdy <= w_rx_ok | (r_resp_rdy & ~w_accept);
`else
      r_resp_rdy <= w_rx_ok;
`endif
    end
  assign bus.cmd_snt = r_cmd_snt;
  assign bus.resp = r_resp;
  assign bus.resp_rdy = r_resp_rdy;
endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: directed bench for remote_comm with a TX-decoding monitor and a loopback receiver
module tb_remote_comm;
  localparam int BD = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_line = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [9:0] tx_q[$];
  logic [7:0] rx2_q[$];
  int rdy1_cnt = 0;
  int snt_rises = 0;
  logic snt_prev = 1'b0;
  remote_comm_if if1();
  remote_comm_if if2();
  assign if1.RX = rx_line;
  assign if2.RX = if1.TX;
  remote_comm #(.BAUD_DIV(BD)) dut (.clk(clk), .rst_n(rst_n), .bus(if1));
  remote_comm #(.BAUD_DIV(BD)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (if1.resp_rdy === 1'b1) rdy1_cnt <= rdy1_cnt + 1;
    if (if2.resp_rdy === 1'b1) rx2_q.push_back(if2.resp);
    if (if1.cmd_snt === 1'b1 && snt_prev !== 1'b1) snt_rises <= snt_rises + 1;
    snt_prev <= if1.cmd_snt;
  end
  // decodes every frame on dut TX into {stop, data, start}, sampling mid-bit
  initial forever begin
    logic [9:0] f;
    @(negedge if1.TX);
    repeat (BD / 2) @(negedge clk);
    f[0] = if1.TX;
    for (int i = 1; i < 10; i++) begin
      repeat (BD) @(negedge clk);
      f[i] = if1.TX;
    end
    tx_q.push_back(f);
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic send_cmd(input logic [15:0] c);
    @(posedge clk);
    #1;
    if1.cmd = c;
    if1.snd_cmd = 1'b1;
    @(posedge clk);
    #1;
    if1.snd_cmd = 1'b0;
    if1.cmd = ~c;
  endtask
  task automatic wait_snt(output int n);
    n = 0;
    while (if1.cmd_snt !== 1'b1 && n < 30 * BD) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      rx_line = f[i];
      repeat (BD) @(posedge clk);
      #1;
    end
    rx_line = 1'b1;
  endtask
  task automatic test_reset;
    if1.cmd = 16'h0000;
    if1.snd_cmd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if1.TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", if1.TX); end
    checks++; if (if1.cmd_snt !== 1'b0) begin errors++; $display("FAIL reset_cmd_snt: got %b expected 0", if1.cmd_snt); end
    checks++; if (if1.resp_rdy !== 1'b0) begin errors++; $display("FAIL reset_resp_rdy: got %b expected 0", if1.resp_rdy); end
    checks++; if (if1.resp !== 8'h00) begin errors++; $display("FAIL reset_resp: got %h expected 00", if1.resp); end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask
  task automatic test_tx_4002;
    int n;
    logic [9:0] f;
    tx_q.delete();
    send_cmd(16'h4002);
    wait_snt(n);
    checks++; if (n < 20 * BD + 1 || n > 20 * BD + 4) begin errors++; $display("FAIL tx_time: got %0d clocks expected %0d..%0d", n, 20 * BD + 1, 20 * BD + 4); end
    repeat (2 * BD) @(posedge clk);
    #1;
    checks++; if (tx_q.size() != 2) begin errors++; $display("FAIL tx_count: got %0d frames expected 2", tx_q.size()); end
    f = (tx_q.size() > 0) ? tx_q.pop_front() : 10'h000;
    checks++; if (f !== {1'b1, 8'h40, 1'b0}) begin errors++; $display("FAIL tx_hi_frame: got %h expected %h", f, {1'b1, 8'h40, 1'b0}); end
    f = (tx_q.size() > 0) ? tx_q.pop_front() : 10'h000;
    checks++; if (f !== {1'b1, 8'h02, 1'b0}) begin errors++; $display("FAIL tx_lo_frame: got %h expected %h", f, {1'b1, 8'h02, 1'b0}); end
    checks++; if (if1.cmd_snt !== 1'b1) begin errors++; $display("FAIL tx_cmd_snt_held: got %b expected 1", if1.cmd_snt); end
  endtask
  task automatic test_loopback_duplex;
    int n;
    int c0;
    rx2_q.delete();
    c0 = rdy1_cnt;
    fork
      begin
        send_cmd(16'h5BF1);
        wait_snt(n);
      end
      rx_frame(8'h96, 1'b1);
    join
    repeat (2 * BD) @(posedge clk);
    #1;
    checks++; if (rx2_q.size() != 2) begin errors++; $display("FAIL loop_count: got %0d bytes expected 2", rx2_q.size()); end
    checks++; if (rx2_q.size() > 0 && rx2_q[0] !== 8'h5B) begin errors++; $display("FAIL loop_byte0: got %h expected 5B", rx2_q[0]); end
    checks++; if (rx2_q.size() > 1 && rx2_q[1] !== 8'hF1) begin errors++; $display("FAIL loop_byte1: got %h expected F1", rx2_q[1]); end
    checks++; if (rdy1_cnt != c0 + 1) begin errors++; $display("FAIL duplex_pulses: got %0d expected %0d", rdy1_cnt - c0, 1); end
    checks++; if (if1.resp !== 8'h96) begin errors++; $display("FAIL duplex_resp: got %h expected 96", if1.resp); end
    tx_q.delete();
  endtask
  task automatic test_rx_a5;
    int c0;
    c0 = rdy1_cnt;
    rx_frame(8'hA5, 1'b1);
    repeat (2 * BD) @(posedge clk);
    #1;
    checks++; if (rdy1_cnt != c0 + 1) begin errors++; $display("FAIL a5_pulses: got %0d expected 1", rdy1_cnt - c0); end
    checks++; if (if1.resp !== 8'hA5) begin errors++; $display("FAIL a5_resp: got %h expected A5", if1.resp); end
    repeat (3 * BD) @(posedge clk);
    #1;
    checks++; if (if1.resp !== 8'hA5 || if1.resp_rdy !== 1'b0) begin errors++; $display("FAIL a5_hold: got resp=%h rdy=%b expected A5/0", if1.resp, if1.resp_rdy); end
  endtask
  task automatic test_ignore_busy;
    int n;
    int s0;
    logic [9:0] f;
    tx_q.delete();
    s0 = snt_rises;
    send_cmd(16'h47F1);
    repeat (3 * BD) @(posedge clk);
    #1;
    if1.cmd = 16'h53F2;
    if1.snd_cmd = 1'b1;
    @(posedge clk);
    #1;
    if1.snd_cmd = 1'b0;
    wait_snt(n);
    checks++; if (n >= 30 * BD) begin errors++; $display("FAIL ignore_timeout: got %0d clocks expected below %0d", n, 30 * BD); end
    repeat (14 * BD) @(posedge clk);
    #1;
    checks++; if (tx_q.size() != 2) begin errors++; $display("FAIL ignore_count: got %0d frames expected 2", tx_q.size()); end
    f = (tx_q.size() > 0) ? tx_q.pop_front() : 10'h000;
    checks++; if (f !== {1'b1, 8'h47, 1'b0}) begin errors++; $display("FAIL ignore_hi: got %h expected %h", f, {1'b1, 8'h47, 1'b0}); end
    f = (tx_q.size() > 0) ? tx_q.pop_front() : 10'h000;
    checks++; if (f !== {1'b1, 8'hF1, 1'b0}) begin errors++; $display("FAIL ignore_lo: got %h expected %h", f, {1'b1, 8'hF1, 1'b0}); end
    checks++; if (snt_rises != s0 + 1) begin errors++; $display("FAIL ignore_snt_once: got %0d rises expected 1", snt_rises - s0); end
  endtask
  task automatic test_rx_errors;
    int c0;
    c0 = rdy1_cnt;
    @(posedge clk);
    #1;
    rx_line = 1'b0;
    repeat (BD / 2 - 3) @(posedge clk);
    #1;
    rx_line = 1'b1;
    repeat (12 * BD) @(posedge clk);
    #1;
    checks++; if (rdy1_cnt != c0) begin errors++; $display("FAIL glitch_pulse: got %0d pulses expected 0", rdy1_cnt - c0); end
    rx_frame(8'h3C, 1'b0);
    repeat (2 * BD) @(posedge clk);
    #1;
    checks++; if (rdy1_cnt != c0) begin errors++; $display("FAIL frame_err_pulse: got %0d pulses expected 0", rdy1_cnt - c0); end
    checks++; if (if1.resp !== 8'hA5) begin errors++; $display("FAIL frame_err_resp: got %h expected A5", if1.resp); end
    rx_frame(8'h3C, 1'b1);
    repeat (2 * BD) @(posedge clk);
    #1;
    checks++; if (rdy1_cnt != c0 + 1 || if1.resp !== 8'h3C) begin errors++; $display("FAIL recover_rx: got %0d pulses resp=%h expected 1 pulse resp=3C", rdy1_cnt - c0, if1.resp); end
  endtask
  task automatic test_reset_mid;
    int n;
    logic [9:0] f;
    send_cmd(16'hC3A7);
    repeat (5 * BD) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (if1.TX !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b expected 1", if1.TX); end
    checks++; if (if1.cmd_snt !== 1'b0) begin errors++; $display("FAIL midrst_cmd_snt: got %b expected 0", if1.cmd_snt); end
    checks++; if (if1.resp !== 8'h00) begin errors++; $display("FAIL midrst_resp: got %h expected 00", if1.resp); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (12 * BD) @(posedge clk);
    tx_q.delete();
    send_cmd(16'h8E3D);
    wait_snt(n);
    checks++; if (n < 20 * BD + 1 || n > 20 * BD + 4) begin errors++; $display("FAIL midrst_time: got %0d clocks expected %0d..%0d", n, 20 * BD + 1, 20 * BD + 4); end
    repeat (2 * BD) @(posedge clk);
    #1;
    checks++; if (tx_q.size() != 2) begin errors++; $display("FAIL midrst_count: got %0d frames expected 2", tx_q.size()); end
    f = (tx_q.size() > 0) ? tx_q.pop_front() : 10'h000;
    checks++; if (f !== {1'b1, 8'h8E, 1'b0}) begin errors++; $display("FAIL midrst_hi: got %h expected %h", f, {1'b1, 8'h8E, 1'b0}); end
    f = (tx_q.size() > 0) ? tx_q.pop_front() : 10'h000;
    checks++; if (f !== {1'b1, 8'h3D, 1'b0}) begin errors++; $display("FAIL midrst_lo: got %h expected %h", f, {1'b1, 8'h3D, 1'b0}); end
  endtask
  initial begin
    test_reset();
    test_tx_4002();
    test_loopback_duplex();
    test_rx_a5();
    test_ignore_busy();
    test_rx_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/remote_comm.md
Name: remote_comm

Overview:
- Host-side command link for the Knight robot. Takes a 16-bit command, serializes it as two UART bytes (high byte first) on TX, and receives the 8-bit response byte on RX.
- Self-contained: integrates its own UART transmitter and receiver (8N1).
- Used by system benches and by the remote controller to drive the KnightsTour top level. The top level answers each command with 0xA5 (positive ack).

Parameters:
BAUD_DIV, 2604, clocks per UART bit (50 MHz / 19200 baud); must be >= 8.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
RX  in  1  serial input from DUT (asynchronous, idle high)
TX  out  1  serial output to DUT (idle high)
cmd  in  16  command word; sampled when snd_cmd is accepted
snd_cmd  in  1  one-cycle request to send cmd
cmd_snt  out  1  high once both bytes have fully left TX
resp_rdy  out  1  one-cycle pulse: new response byte in resp
resp  out  8  last received byte; held until the next byte arrives

Behaviour:
- Reset values: TX=1, cmd_snt=0, resp_rdy=0, resp=0x00, FSM=IDLE, both UART engines idle.

Command FSM (states IDLE, SEND_HI, SEND_LO):
- IDLE + snd_cmd:
  - Latch cmd into a 16-bit register.
  - Clear cmd_snt.
  - Start the TX of cmd[15:8] on the next cycle.
  - Go to SEND_HI.
- SEND_HI: when TX reports byte done, start cmd[7:0] in the following cycle; go to SEND_LO.
- SEND_LO: when TX reports byte done, set cmd_snt=1; go to IDLE.
- snd_cmd while not in IDLE is ignored. The latched command is unaffected; cmd changes after acceptance have no effect.
- cmd_snt stays high until the next accepted snd_cmd.

UART TX:
- Frame: start bit 0, data bits LSB first, stop bit 1. Each bit lasts exactly BAUD_DIV clocks, so a frame is 10*BAUD_DIV clocks.
- Byte done asserts in the cycle the stop bit period ends.
- Back-to-back: the gap between the hi stop bit and the lo start bit is at most 2 clocks.

UART RX:
- RX passes through a two-flop synchronizer, preset to 1 on reset.
- Idle-state falling edge starts reception.
- First sample is at BAUD_DIV/2 (mid start bit); subsequent samples every BAUD_DIV.
- If the start bit samples 1, it is a false start: return to idle with no output.
- Data shifts in LSB first.
- On the stop bit sample:
  - Stop = 1: load resp, pulse resp_rdy for exactly one clock.
  - Stop = 0 (framing error): discard; resp unchanged; no resp_rdy.
- RX operates fully independently of TX (full duplex). A response may arrive while a command is being sent.

Other rules:
- Asynchronous reset mid-frame: TX returns high immediately, FSM goes to IDLE, any partial RX byte is lost.
- Simultaneous snd_cmd and resp_rdy: both handled; no interaction.

Optional Feature:
- Macro: RC_RESP_STICKY_EN.
- Defined: resp_rdy is a level. It sets on a valid received byte and clears on the next accepted snd_cmd. If a new byte arrives while it is still set, resp updates and resp_rdy stays 1.
- Undefined: resp_rdy is the one-cycle pulse described above.

Test Plan:
- Reset, then snd_cmd with cmd=16'h4002:
  - TX shows 0x40 then 0x02, 8N1, LSB first, each bit 2604 clocks.
  - cmd_snt rises within 2 clocks of the second stop bit end.
  - Total time is about 52080 clocks.
- Loop TX into a second instance RX; send 16'h5BF1 → two resp_rdy pulses with resp=0x5B then 0xF1.
- Drive an 0xA5 frame on RX → exactly one resp_rdy pulse; resp=0xA5 and held afterwards.
- snd_cmd with 16'h47F1, then pulse snd_cmd=16'h53F2 during SEND_HI → only 0x47, 0xF1 are transmitted; cmd_snt=1 once.
- Timing and error frames on RX:
  - RX glitch low for under BAUD_DIV/2 clocks → no resp_rdy.
  - Frame 0x3C with stop bit 0 → no resp_rdy, resp keeps its prior value.
- Assert rst_n low mid-way through the hi byte → TX=1 immediately, cmd_snt=0; a new snd_cmd after release sends both bytes correctly.
